fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
// - Parametrised instruction-fetch front end for the pipelined core; sits between instruction memory and decode.
// - Owns the fetch PC and issues sequential fetch requests to a 1-cycle-latency synchronous instruction memory.
// - Buffers up to DEPTH fetched instructions with their PCs and presents them to decode on a valid/ready handshake.
// - Flushes its contents and refetches from a new PC when a taken branch/jump redirect arrives.
// PARAMETERS
// - XLEN      32     address/instruction width
// - DEPTH     4      queue entries; power of two, >= 2
// - RESET_PC  32'h0  fetch PC after reset
// PORTS
// - clk          in   1     single clock, rising edge
// - rst          in   1     asynchronous, active-high reset
// - redirect     in   1     taken branch/jump this cycle
// - redirect_pc  in   XLEN  new fetch target; bits [1:0] ignored (treated as 0)
// - imem_req     out  1     fetch request this cycle
// - imem_addr    out  XLEN  fetch address (equals the fetch PC)
// - imem_rdata   in   XLEN  instruction data; valid exactly 1 cycle after an accepted imem_req
// - dec_valid    out  1     head entry valid for decode
// - dec_ready    in   1     decode accepts head entry (pop when dec_valid && dec_ready)
// - dec_instr    out  XLEN  head instruction; 32'h00000013 (NOP) when dec_valid=0
// - dec_pc       out  XLEN  PC of head instruction; 0 when dec_valid=0
// BEHAVIOUR
// - Reset (async): fetch_pc=RESET_PC, count=0, rd/wr pointers=0, inflight=0.
//   Outputs during reset: imem_req=0, dec_valid=0, dec_instr=NOP, dec_pc=0.
// - Credit rule: imem_req = !redirect && (count + inflight) < DEPTH. Overflow is impossible by construction.
// - On imem_req: fetch_pc <= fetch_pc + 4 (modulo 2^XLEN, wraps silently); inflight <= 1; req_pc <= fetch_pc.
// - Response cycle (inflight=1, no redirect): push {imem_rdata, req_pc} at wr_ptr; wr_ptr wraps at DEPTH.
// - Pop: dec_valid && dec_ready advances rd_ptr (wraps at DEPTH).
//   Push and pop in the same cycle leave count unchanged, including at count=DEPTH-1 and at count=DEPTH with pop.
// - dec_valid = (count != 0) && !redirect; redirect combinationally kills the head for that cycle, so no pop occurs.
// - Redirect cycle:
//   - next edge: count=0, rd_ptr=wr_ptr=0, fetch_pc=redirect_pc&~3, inflight=0;
//   - any response arriving in the redirect cycle is discarded;
//   - imem_req resumes the cycle after redirect at the new PC.
// - Back-to-back redirects: the last one wins; each cycle of redirect re-applies the flush.
// - Latency, empty queue, dec_ready=1: imem_req at cycle N -> dec_valid at N+2 with that instruction.
// - Steady state with dec_ready=1: one instruction per cycle.
// - dec_ready=0: the queue fills to DEPTH; then imem_req drops until a pop frees a credit.
// CONFIGURATION
// - FQ_BYPASS_EN defined: when count==0 and a response arrives (no redirect), it is presented directly.
//   - dec_valid=1, dec_instr=imem_rdata, dec_pc=req_pc in that same cycle.
//   - If dec_ready=1, the instruction is not written to the queue.
//   - If dec_ready=0, it is written as normal.
//   - Min latency req->dec_valid = 1 cycle.
// - FQ_BYPASS_EN undefined: every response is written to the queue first. Min latency = 2 cycles.
// - Functional ordering and credit rule are identical in both builds.
// TESTING
// - Reset release, RESET_PC=0, dec_ready=1 -> imem_addr 0,4,8,... one per cycle; dec_pc 0,4,8 in order.
//   - Without bypass: first dec_valid 2 cycles after the first req.
// - dec_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 reqs issued, count=4, imem_req=0.
//   - Then dec_ready=1 -> entries drain PC 0,4,8,12 with no loss or duplication.
// - Redirect to 32'h100 while 3 entries queued and 1 inflight -> dec_valid=0 in the redirect cycle.
//   - Inflight response dropped; next imem_addr=32'h100; next dec_pc=32'h100.
// - redirect_pc=32'h203 -> next fetch at 32'h200.
// - fetch_pc=32'hFFFFFFFC, continuous fetch -> next imem_addr=32'h0; dec_pc order FFFFFFFC then 0.
// - Assert rst mid-stream with queue full -> outputs drop to reset values immediately (async).
//   - After release, the first fetch is at RESET_PC.
// - FQ_BYPASS_EN, empty queue, dec_ready=1 -> dec_valid the cycle after req with dec_instr=imem_rdata.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem requests under a
// credit limit and buffers responses for decode. Define FQ_BYPASS_EN to present a response straight to decode when empty.
module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);

  localparam int              PW  = $clog2(DEPTH);
  localparam int              CW  = PW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic head_valid;
  logic resp;
  logic byp;
  logic push;
  logic pop;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    head_valid = (count_q != '0);
    resp       = inflight_q && !redirect;
`ifdef FQ_BYPASS_EN
    byp        = resp && !head_valid;
`else
    byp        = 1'b0;
`endif

    // Credits cover both queued entries and the one response still in flight.
    imem_req  = !rst && !redirect && ((count_q + CW'(inflight_q)) < CW'(DEPTH));
    imem_addr = fetch_pc_q;

    dec_valid = (head_valid || byp) && !redirect;
    dec_instr = NOP;
    dec_pc    = '0;
    if (dec_valid) begin
      if (head_valid) begin
        dec_instr = instr_mem[rd_ptr_q];
        dec_pc    = pc_mem[rd_ptr_q];
      end else begin
        dec_instr = imem_rdata;
        dec_pc    = req_pc_q;
      end
    end

    pop  = dec_valid && dec_ready && head_valid;
    push = resp && !(byp && dec_ready);

    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;

    if (imem_req) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      req_pc_d   = fetch_pc_q;
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: storage is not reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: in-order PC/instruction scoreboard, credit model and
// directed checks for latency, back-pressure, redirect, wrap and async reset.
module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FQ_BYPASS_EN
  localparam int          LAT      = 1;
`else
  localparam int          LAT      = 2;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] seg_next;
  logic [31:0] exp_fetch;
  int          occ;
  int          checks;
  int          errors;

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  // Instruction memory: data for an accepted request appears one cycle later, junk otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? ifn(imem_addr) : $urandom();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected decode stream is the sequential PC run from the latest restart point.
  task automatic top_up();
    while (exp_q.size() < 32) begin
      exp_q.push_back('{pc: seg_next, instr: ifn(seg_next)});
      seg_next += 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    seg_next = pc & ~32'h3;
    top_up();
  endtask

  task automatic step(input logic rd, input logic rdr, input logic [31:0] rpc);
    @(posedge clk); #1;
    dec_ready   = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    if (rdr) restart_stream(rpc);
    top_up();
  endtask

  task automatic reset_dut(input logic rd);
    @(posedge clk); #1;
    rst       = 1'b1;
    redirect  = 1'b0;
    dec_ready = rd;
    restart_stream(RESET_PC);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  // Monitor: samples mid-cycle, when inputs and outputs for the coming edge are settled.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_imem_req", 32'(imem_req), 32'd0);
      check("rst_dec_valid", 32'(dec_valid), 32'd0);
      exp_fetch = RESET_PC;
      occ       = 0;
    end else begin
      check("credit_req", 32'(imem_req), 32'(!redirect && occ < DEPTH));
      if (imem_req) check("imem_addr", imem_addr, exp_fetch);
      if (redirect) check("redirect_kills_valid", 32'(dec_valid), 32'd0);
      if (!dec_valid) begin
        check("idle_instr", dec_instr, NOP);
        check("idle_pc", dec_pc, 32'd0);
      end
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e.pc);
          check("dec_instr", dec_instr, e.instr);
        end
      end
      if (redirect) begin
        exp_fetch = redirect_pc & ~32'h3;
        occ       = 0;
      end else begin
        occ = occ + int'(imem_req) - int'(dec_valid && dec_ready);
        if (imem_req) exp_fetch += 32'd4;
      end
    end
  end

  initial begin
    int first_req;
    int first_val;
    int nreq;
    bit found;

    checks      = 0;
    errors      = 0;
    occ         = 0;
    exp_fetch   = RESET_PC;
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    dec_ready   = 1'b0;
    restart_stream(RESET_PC);

    #1 rst = 1'b1;
    #2;
    check("reset_imem_req", 32'(imem_req), 32'd0);
    check("reset_dec_valid", 32'(dec_valid), 32'd0);
    check("reset_dec_instr", dec_instr, NOP);
    check("reset_dec_pc", dec_pc, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    dec_ready = 1'b1;

    // First request right after release; decode sees it LAT cycles later.
    first_req = -1;
    first_val = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req && first_req < 0) first_req = i;
      if (dec_valid && first_val < 0) first_val = i;
    end
    check("first_req_cycle", 32'(first_req), 32'd0);
    check("req_to_valid_latency", 32'(first_val - first_req), 32'(LAT));

    // Fill the queue, then hit async reset mid-cycle.
    repeat (10) step(1'b0, 1'b0, 32'h0);
    @(negedge clk); #2;
    check("full_before_rst", 32'(dec_valid), 32'd1);
    rst = 1'b1;
    restart_stream(RESET_PC);
    #1;
    check("async_rst_imem_req", 32'(imem_req), 32'd0);
    check("async_rst_dec_valid", 32'(dec_valid), 32'd0);
    check("async_rst_dec_instr", dec_instr, NOP);
    check("async_rst_dec_pc", dec_pc, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dec_ready = 1'b0;

    // Back-pressure: exactly DEPTH requests, then the request line stays low.
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("addr_after_reset", imem_addr, RESET_PC);
      if (imem_req) nreq++;
    end
    check("reqs_while_stalled", 32'(nreq), 32'(DEPTH));
    check("req_low_when_full", 32'(imem_req), 32'd0);
    repeat (8) step(1'b1, 1'b0, 32'h0);

    // Redirect with three entries queued and one response in flight.
    reset_dut(1'b0);
    nreq  = 0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) nreq++;
      else if (nreq > 0) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("stall_point_found", 32'(found), 32'd1);
    check("reqs_before_stall", 32'(nreq), 32'(DEPTH));
    dec_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    restart_stream(32'h100);
    #1;
    check("redirect_cycle_valid", 32'(dec_valid), 32'd0);
    check("redirect_cycle_req", 32'(imem_req), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("addr_after_redirect", imem_addr, 32'h100);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Low address bits of the target are ignored.
    step(1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("addr_aligned", imem_addr, 32'h200);
    repeat (4) step(1'b1, 1'b0, 32'h0);

    // Fetch PC wraps from the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check("addr_wrapped", imem_addr, 32'h0);
    repeat (6) step(1'b1, 1'b0, 32'h0);

    // Random back-pressure and redirects, including back-to-back ones.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 3), $urandom());
    repeat (4) step(1'b1, 1'b0, 32'h0);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
